serial_rx: RTL and testbench

Receive end of the Tx serial link. Takes the single-bit stream produced by the transmitter at one bit per `clk_32f`, finds byte alignment on comma `0xBC`, and converts the stream back to four 8-bit lanes with per-lane valid flags. It sits at the PHY Rx input and drives the lane FIFOs / checker.

---
 rtl/serial_rx_if.sv | 30 +++
 rtl/serial_rx.sv | 151 +++++++++++++++
 tb/tb_serial_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_rx_if.sv
// Recovered-lane bundle of the serial receiver: one serial bit in, four lane bytes out.
// The slave modport belongs to the receiver, the master modport to the bit source and lane sink.
interface serial_rx_if;
    logic       data_in;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       active;
    logic       IDLE_out;
    logic       frame_strobe;

    modport master (
        output data_in,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  active, IDLE_out, frame_strobe
    );

    modport slave (
        input  data_in,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output active, IDLE_out, frame_strobe
    );
endinterface

// File: rtl/serial_rx.sv
// Serial receiver: finds byte alignment on repeated commas, then deserialises
// the bit stream into four rotating lane bytes with per-lane valid flags.
//
// state  | meaning
// HUNT   | bit-level search for a comma in the shift register
// COUNT  | byte-aligned, counting consecutive commas up to ALIGN_COUNT
// ACTIVE | locked; every completed byte updates the current lane
module serial_rx #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter logic [7:0] INVALID     = 8'h7C,
    parameter int         ALIGN_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        rst,
    serial_rx_if.slave  rx
);
    localparam int BC_W = $clog2(ALIGN_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state_q,       state_d;
    logic [7:0]      sr_q,          sr_d;
    logic [2:0]      bit_cnt_q,     bit_cnt_d;
    logic [BC_W-1:0] bc_cnt_q,      bc_cnt_d;
    logic [1:0]      lane_q,        lane_d;
    logic [3:0][7:0] lane_byte_q,   lane_byte_d;
    logic [3:0]      valid_q,       valid_d;
    logic            frame_comma_q, frame_comma_d;
    logic            idle_q,        idle_d;
    logic            strobe_q,      strobe_d;

    logic is_comma;
    logic is_invalid;
    logic byte_done;

    assign is_comma   = (sr_q == COMMA);
    assign is_invalid = (sr_q == INVALID);
    // bit_cnt wraps to 0 the cycle after a byte's LSB lands in sr
    assign byte_done  = (bit_cnt_q == 3'd0);

    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            bc_cnt_q      <= '0;
            lane_q        <= '0;
            lane_byte_q   <= '0;
            valid_q       <= '0;
            frame_comma_q <= 1'b0;
            idle_q        <= 1'b0;
            strobe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            bc_cnt_q      <= bc_cnt_d;
            lane_q        <= lane_d;
            lane_byte_q   <= lane_byte_d;
            valid_q       <= valid_d;
            frame_comma_q <= frame_comma_d;
            idle_q        <= idle_d;
            strobe_q      <= strobe_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = {sr_q[6:0], rx.data_in};
        bit_cnt_d     = bit_cnt_q + 3'd1;
        bc_cnt_d      = bc_cnt_q;
        lane_d        = lane_q;
        lane_byte_d   = lane_byte_q;
        valid_d       = valid_q;
        frame_comma_d = frame_comma_q;
        idle_d        = idle_q;
        strobe_d      = 1'b0;

        unique case (state_q)
            HUNT: begin
                bit_cnt_d = 3'd0;
                bc_cnt_d  = '0;
                if (is_comma) begin
                    state_d   = COUNT;
                    bc_cnt_d  = BC_W'(1);
                    bit_cnt_d = 3'd1;
                end
            end

            COUNT: begin
                if (byte_done) begin
                    if (is_comma) begin
                        if (bc_cnt_q == BC_W'(ALIGN_COUNT - 1)) begin
                            state_d  = ACTIVE;
                            bc_cnt_d = BC_W'(ALIGN_COUNT);
                            lane_d   = 2'd0;
                        end else begin
                            bc_cnt_d = bc_cnt_q + BC_W'(1);
                        end
                    end else begin
                        // bits already in sr are searched again from the next cycle
                        state_d   = HUNT;
                        bc_cnt_d  = '0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                if (byte_done) begin
                    lane_d = lane_q + 2'd1;
                    if (is_comma || is_invalid) begin
                        valid_d[lane_q] = 1'b0;
                    end else begin
                        lane_byte_d[lane_q] = sr_q;
                        valid_d[lane_q]     = 1'b1;
                    end
                    if (lane_q == 2'd0) begin
                        frame_comma_d = is_comma;
                    end else begin
                        frame_comma_d = frame_comma_q & is_comma;
                    end
                    if (lane_q == 2'd3) begin
                        idle_d   = frame_comma_q & is_comma;
                        strobe_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    assign rx.out0         = lane_byte_q[0];
    assign rx.out1         = lane_byte_q[1];
    assign rx.out2         = lane_byte_q[2];
    assign rx.out3         = lane_byte_q[3];
    assign rx.valid_out0   = valid_q[0];
    assign rx.valid_out1   = valid_q[1];
    assign rx.valid_out2   = valid_q[2];
    assign rx.valid_out3   = valid_q[3];
    assign rx.active       = (state_q == ACTIVE);
    assign rx.IDLE_out     = idle_q;
    assign rx.frame_strobe = strobe_q;
endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: reset, comma alignment, lane data, invalid slots,
// broken alignment and mid-frame reset, all against hand-computed values.
module tb_serial_rx;
    logic clk_32f = 1'b0;
    logic rst     = 1'b0;

    always #5 clk_32f = ~clk_32f;

    serial_rx_if rx_if ();

    serial_rx dut (
        .clk_32f (clk_32f),
        .rst     (rst),
        .rx      (rx_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] all_outs();
        return {rx_if.out0, rx_if.out1, rx_if.out2, rx_if.out3,
                rx_if.valid_out0, rx_if.valid_out1, rx_if.valid_out2, rx_if.valid_out3,
                rx_if.active, rx_if.IDLE_out, rx_if.frame_strobe};
    endfunction

    function automatic logic [31:0] lanes();
        return {rx_if.out0, rx_if.out1, rx_if.out2, rx_if.out3};
    endfunction

    function automatic logic [3:0] valids();
        return {rx_if.valid_out0, rx_if.valid_out1, rx_if.valid_out2, rx_if.valid_out3};
    endfunction

    // drive one bit, let the next rising edge sample it, then settle
    task automatic send_bit(input logic b);
        rx_if.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    initial begin
        rx_if.data_in = 1'b0;

        // reset held with noise on the line
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        check_eq("reset_outs", 64'(all_outs()), 64'd0);
        rst = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("post_reset_garbage", 64'(all_outs()), 64'd0);

        // alignment: commas 1..4 lock, 5..8 form an idle frame
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_eq("active_after_3_commas", 64'(rx_if.active), 64'd0);
        send_byte(8'hBC);
        check_eq("active_at_4th_lsb", 64'(rx_if.active), 64'd0);
        send_bits(8'hBC, 7, 7);
        check_eq("active_rise", 64'(rx_if.active), 64'd1);
        send_bits(8'hBC, 6, 0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        check_eq("idle_before_frame_end", 64'(rx_if.IDLE_out), 64'd0);
        send_bits(8'hFF, 7, 7);
        check_eq("idle_set", 64'(rx_if.IDLE_out), 64'd1);
        check_eq("idle_frame_strobe", 64'(rx_if.frame_strobe), 64'd1);
        check_eq("idle_frame_valids", 64'(valids()), 64'd0);

        // data frame FF,FA,BA,FF
        send_bits(8'hFF, 6, 0);
        check_eq("out0_not_yet", 64'(rx_if.out0), 64'd0);
        send_bits(8'hFA, 7, 7);
        check_eq("out0_update", 64'({rx_if.out0, rx_if.valid_out0}), 64'({8'hFF, 1'b1}));
        send_bits(8'hFA, 6, 0);
        send_byte(8'hBA);
        send_byte(8'hFF);
        send_bits(8'hFF, 7, 7);
        check_eq("data_lanes", 64'(lanes()), 64'h00000000_FFFABAFF);
        check_eq("data_valids", 64'(valids()), 64'b1111);
        check_eq("data_idle", 64'(rx_if.IDLE_out), 64'd0);
        check_eq("data_strobe", 64'(rx_if.frame_strobe), 64'd1);
        send_bits(8'hFF, 6, 6);
        check_eq("strobe_one_cycle", 64'(rx_if.frame_strobe), 64'd0);

        // invalid slots: FF,7C,BA,BC
        send_bits(8'hFF, 5, 0);
        send_byte(8'h7C);
        send_byte(8'hBA);
        send_byte(8'hBC);
        send_bits(8'h11, 7, 7);
        check_eq("inval_lanes", 64'(lanes()), 64'h00000000_FFFABAFF);
        check_eq("inval_valids", 64'(valids()), 64'b1010);
        check_eq("inval_idle", 64'(rx_if.IDLE_out), 64'd0);
        check_eq("inval_strobe", 64'(rx_if.frame_strobe), 64'd1);

        // mid-frame reset, 5 bits into lane 2
        send_bits(8'h11, 6, 0);
        send_bits(8'h22, 7, 7);
        check_eq("lane0_11", 64'({rx_if.out0, rx_if.valid_out0}), 64'({8'h11, 1'b1}));
        send_bits(8'h22, 6, 0);
        send_bits(8'h33, 7, 3);
        check_eq("active_before_rst", 64'(rx_if.active), 64'd1);
        rst = 1'b0;
        #2;
        check_eq("async_rst_clear", 64'(all_outs()), 64'd0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        rst = 1'b1;

        // broken alignment: 3 commas, 0x55, then a full 4-comma run
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_eq("relock_3_commas", 64'(rx_if.active), 64'd0);
        send_byte(8'h55);
        check_eq("after_break", 64'(rx_if.active), 64'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_eq("break_3_commas", 64'(rx_if.active), 64'd0);
        send_byte(8'hBC);
        check_eq("break_4th_lsb", 64'(rx_if.active), 64'd0);
        send_bits(8'h42, 7, 7);
        check_eq("break_active_rise", 64'(rx_if.active), 64'd1);
        send_bits(8'h42, 6, 0);
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h45);
        send_bits(8'hBC, 7, 7);
        check_eq("relock_lanes", 64'(lanes()), 64'h00000000_42434445);
        check_eq("relock_valids", 64'(valids()), 64'b1111);
        check_eq("relock_strobe", 64'(rx_if.frame_strobe), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
